// File: rtl/pdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pdm_pkg
// Brief    : Shared PDM serial-link defaults and serializer state type.
// Revision : 1.0 - initial release
// ============================================================================
package pdm_pkg;

    localparam int unsigned C_WORD_W  = 16;
    localparam int unsigned C_CLK_DIV = 100;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage : pdm_pkg
`default_nettype wire

// File: rtl/pdm_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : pdm_serializer_if
// Brief    : Valid/ready sample-word stream into the PDM serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface pdm_serializer_if #(
    parameter int unsigned WORD_W = pdm_pkg::C_WORD_W
);
    logic              s_valid;
    logic [WORD_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface : pdm_serializer_if
`default_nettype wire

// File: rtl/pdm_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : pdm_clk_div
// Brief    : Bit-period divider: bit_tick strobe and registered 50% bit clock.
// Revision : 1.0 - initial release
// ============================================================================
module pdm_clk_div #(
    parameter int unsigned CLK_DIV = pdm_pkg::C_CLK_DIV
) (
    input  wire  clock,
    input  wire  reset_n,
    input  wire  enable,
    output logic bit_tick,
    output logic pdm_clk_o
);
    localparam int unsigned         C_CNT_W = $clog2(CLK_DIV);
    localparam logic [C_CNT_W-1:0]  C_LAST  = C_CNT_W'(CLK_DIV - 1);
    localparam logic [C_CNT_W-1:0]  C_HALF  = C_CNT_W'(CLK_DIV / 2);

    logic [C_CNT_W-1:0] r_div_cnt;
    logic [C_CNT_W-1:0] w_div_nxt;
    logic               r_pdm_clk;

    always_comb begin
        w_div_nxt = '0;
        if (enable && (r_div_cnt != C_LAST))
            w_div_nxt = r_div_cnt + 1'b1;
    end

    // Clock is derived from the next count so its falling edge lines up with bit_tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_pdm_clk <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_pdm_clk <= (w_div_nxt >= C_HALF);
        end
    end

    assign bit_tick  = enable && (r_div_cnt == C_LAST);
    assign pdm_clk_o = r_pdm_clk;

endmodule : pdm_clk_div
`default_nettype wire

// File: rtl/pdm_serializer.sv
`default_nettype none
// ============================================================================
// Module   : pdm_serializer
// Brief    : 16-bit word to MSB-first PDM bit stream with 1-deep holding register.
//            Define PDM_SIGMA_DELTA_EN for first-order delta-sigma output.
// Revision : 1.0 - initial release
// ============================================================================
module pdm_serializer
    import pdm_pkg::*;
#(
    parameter int unsigned WORD_W  = C_WORD_W,
    parameter int unsigned CLK_DIV = C_CLK_DIV
) (
    input  wire            clock,
    input  wire            reset_n,
    input  wire            enable,
    pdm_serializer_if.slave s,
    output logic           pdm_clk_o,
    output logic           pdm_data_o,
    output logic           done,
    output logic           underrun_o
);
    localparam int unsigned        C_CNT_W    = $clog2(WORD_W);
    localparam logic [C_CNT_W-1:0] C_LAST_BIT = C_CNT_W'(WORD_W - 1);

    ser_state_t         r_state;
    logic [WORD_W-1:0]  r_hold;
    logic [WORD_W-1:0]  r_shift;
    logic [C_CNT_W-1:0] r_bit_cnt;
    logic               r_hold_full;
    logic               r_s_ready;
    logic               r_data;
    logic               r_done;
    logic               r_underrun;

    logic w_tick, w_accept, w_last, w_load, w_emit, w_hold_full_nxt;
    logic w_first_bit, w_next_bit;

    pdm_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .bit_tick  (w_tick),
        .pdm_clk_o (pdm_clk_o)
    );

    assign w_accept        = s.s_valid && r_s_ready;
    assign w_last          = (r_state == SHIFT) && (r_bit_cnt == C_LAST_BIT);
    assign w_load          = w_tick && r_hold_full && ((r_state == IDLE) || w_last);
    assign w_emit          = w_load || (w_tick && (r_state == SHIFT) && !w_last);
    assign w_hold_full_nxt = w_accept || (r_hold_full && !w_load);

`ifdef PDM_SIGMA_DELTA_EN
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] r_acc;
    logic [WORD_W-1:0] w_sd_src;
    logic [WORD_W:0]   w_sum;

    // Offset-binary view of the word being emitted; the carry out is the PDM bit.
    always_comb begin
        w_sd_src = w_load ? r_hold : r_word;
        w_sum    = {1'b0, r_acc} + {1'b0, ~w_sd_src[WORD_W-1], w_sd_src[WORD_W-2:0]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_word <= '0;
            r_acc  <= '0;
        end else if (!enable) begin
            r_word <= '0;
            r_acc  <= '0;
        end else begin
            if (w_load)
                r_word <= r_hold;
            if (w_emit)
                r_acc <= w_sum[WORD_W-1:0];
        end
    end

    assign w_first_bit = w_sum[WORD_W];
    assign w_next_bit  = w_sum[WORD_W];
`else
    assign w_first_bit = r_hold[WORD_W-1];
    assign w_next_bit  = r_shift[WORD_W-2];
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_hold_full <= 1'b0;
            r_s_ready   <= 1'b0;
            r_data      <= 1'b0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else if (!enable) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_hold_full <= 1'b0;
            r_s_ready   <= 1'b0;
            r_data      <= 1'b0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
            r_hold_full <= w_hold_full_nxt;
            r_s_ready   <= !w_hold_full_nxt;
            // A reload in the same cycle reads the old hold before it is overwritten.
            if (w_accept)
                r_hold <= s.s_data;
            if (w_load) begin
                r_shift   <= r_hold;
                r_bit_cnt <= '0;
                r_data    <= w_first_bit;
                r_state   <= SHIFT;
            end
            case (r_state)
                IDLE: begin
                    if (!w_load)
                        r_data <= 1'b0;
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (w_last) begin
                            r_done <= 1'b1;
                            if (!r_hold_full) begin
                                r_underrun <= 1'b1;
                                r_state    <= IDLE;
                                r_data     <= 1'b0;
                            end
                        end else begin
                            r_shift   <= r_shift << 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_data    <= w_next_bit;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s.s_ready  = r_s_ready;
    assign pdm_data_o = r_data;
    assign done       = r_done;
    assign underrun_o = r_underrun;

endmodule : pdm_serializer
`default_nettype wire

// File: tb/tb_pdm_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdm_serializer
// Brief    : Scoreboard bench for pdm_serializer against a word-level line model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdm_serializer;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned CLK_DIV = 4;
    localparam int          HALF    = CLK_DIV / 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b0;
    logic pdm_clk_o, pdm_data_o, done, underrun_o;

    pdm_serializer_if #(.WORD_W(WORD_W)) ifc ();

    pdm_serializer #(.WORD_W(WORD_W), .CLK_DIV(CLK_DIV)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .s          (ifc.slave),
        .pdm_clk_o  (pdm_clk_o),
        .pdm_data_o (pdm_data_o),
        .done       (done),
        .underrun_o (underrun_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [WORD_W-1:0] w;
        int                at_edge;
    } acc_t;

    acc_t              acc_q[$];
    logic              cap[$];
    int                cyc       = 0;
    logic              in_word   = 1'b0;
    logic              just_fin  = 1'b0;
    logic [WORD_W-1:0] cur_w     = '0;
    int                bit_idx   = 0;
    logic [WORD_W-1:0] sd_acc    = '0;
    logic              prev_clk  = 1'b0;
    int                exp_done  = 0, act_done  = 0;
    int                exp_under = 0, act_under = 0;
    int                total     = 0, bad       = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Line model: raw MSB-first bits, or first-order delta-sigma of the word.
    function automatic logic model_bit();
        logic [WORD_W:0] sum;
        sum = '0;
`ifdef PDM_SIGMA_DELTA_EN
        sum    = {1'b0, sd_acc} + {1'b0, ~cur_w[WORD_W-1], cur_w[WORD_W-2:0]};
        sd_acc = sum[WORD_W-1:0];
        return sum[WORD_W];
`else
        return cur_w[WORD_W-1-bit_idx];
`endif
    endfunction

    // Scoreboard push: record accepted words with the edge they were taken on.
    always @(posedge clock) begin
        cyc++;
        if (!reset_n || !enable) begin
            acc_q.delete();
            in_word  = 1'b0;
            just_fin = 1'b0;
            sd_acc   = '0;
        end else if (ifc.s_valid && ifc.s_ready) begin
            acc_q.push_back('{w: ifc.s_data, at_edge: cyc});
        end
    end

    // Monitor: each pdm_clk_o rising edge presents one bit period.
    always @(negedge clock) begin : mon
        acc_t e;
        logic expb;
        if (done === 1'b1)       act_done++;
        if (underrun_o === 1'b1) act_under++;
        if (reset_n && pdm_clk_o && !prev_clk) begin
            // A word appears on the first bit period starting strictly after its accept edge.
            if (!in_word && acc_q.size() > 0 && acc_q[0].at_edge < cyc - HALF) begin
                e        = acc_q.pop_front();
                cur_w    = e.w;
                in_word  = 1'b1;
                bit_idx  = 0;
                just_fin = 1'b0;
            end
            if (in_word) begin
                expb = model_bit();
                cap.push_back(pdm_data_o);
                check("bit", int'(pdm_data_o), int'(expb));
                bit_idx++;
                if (bit_idx == WORD_W) begin
                    in_word  = 1'b0;
                    just_fin = 1'b1;
                    exp_done++;
                end
            end else begin
                if (just_fin) begin
                    exp_under++;
                    just_fin = 1'b0;
                end
                check("idle_bit", int'(pdm_data_o), 0);
            end
        end
        prev_clk = pdm_clk_o;
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic send(input logic [WORD_W-1:0] w);
        int n;
        n = 0;
        ifc.s_valid = 1'b1;
        ifc.s_data  = w;
        while (ifc.s_ready !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL send_timeout: got s_ready=%0b expected 1", ifc.s_ready);
        end
        tick();
        ifc.s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((acc_q.size() != 0 || in_word || just_fin) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
        repeat (2 * CLK_DIV) tick();
    endtask

    task automatic wait_bit(input int idx);
        int n;
        n = 0;
        while (!(in_word && bit_idx == idx) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL bit_wait_timeout: got bit %0d expected %0d", bit_idx, idx);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_s_ready"},  int'(ifc.s_ready), 0);
        check({tag, "_pdm_clk"},  int'(pdm_clk_o),   0);
        check({tag, "_pdm_data"}, int'(pdm_data_o),  0);
        check({tag, "_done"},     int'(done),        0);
        check({tag, "_underrun"}, int'(underrun_o),  0);
    endtask

    function automatic logic [WORD_W-1:0] cap_word(input int first);
        logic [WORD_W-1:0] v;
        v = '0;
        for (int i = 0; i < WORD_W; i++)
            v[WORD_W-1-i] = cap[first+i];
        return v;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int d0, u0, gap;
        ifc.s_valid = 1'b0;
        ifc.s_data  = '0;
        repeat (2) tick();
        check_outputs_zero("reset");

        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (3) tick();
        check("ready_after_reset", int'(ifc.s_ready), 1);

        // Single word from IDLE
        d0 = act_done; u0 = act_under;
        cap.delete();
        send(16'hA5C3);
        wait_idle();
        check("s1_done",  act_done - d0,  1);
        check("s1_under", act_under - u0, 1);
`ifndef PDM_SIGMA_DELTA_EN
        check("s1_size", cap.size(), WORD_W);
        if (cap.size() >= WORD_W)
            check("s1_word", int'(cap_word(0)), 16'hA5C3);
`endif

        // Gap-free stream; third word is offered across the first reload
        d0 = act_done; u0 = act_under;
        send(16'hFFFF);
        send(16'h0000);
        send(16'h8001);
        wait_idle();
        check("s2_done",  act_done - d0,  3);
        check("s2_under", act_under - u0, 1);

        // Enable dropped while bit 7 of 0x1234 is on the line
        d0 = act_done; u0 = act_under;
        send(16'h1234);
        wait_bit(8);
        enable = 1'b0;
        tick();
        check("dis_pdm_clk",  int'(pdm_clk_o),   0);
        check("dis_pdm_data", int'(pdm_data_o),  0);
        check("dis_s_ready",  int'(ifc.s_ready), 0);
        repeat (3 * CLK_DIV) tick();
        check("dis_done",  act_done - d0,  0);
        check("dis_under", act_under - u0, 0);
        enable = 1'b1;
        repeat (2) tick();
        send(16'h00FF);
        wait_idle();
        check("reen_done",  act_done - d0,  1);
        check("reen_under", act_under - u0, 1);

        // Asynchronous reset pulse mid-word, off the clock edges
        d0 = act_done;
        send(16'hBEEF);
        wait_bit(5);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("areset");
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        check("ready_after_areset", int'(ifc.s_ready), 1);
        check("areset_done", act_done - d0, 0);

        // Randomized words and gaps
        for (int i = 0; i < 20; i++) begin
            send(WORD_W'($urandom));
            gap = $urandom_range(0, WORD_W * CLK_DIV + 8);
            repeat (gap) tick();
        end
        wait_idle();
        check("total_done",  act_done,  exp_done);
        check("total_under", act_under, exp_under);

`ifdef PDM_SIGMA_DELTA_EN
        // Fresh accumulator via enable clear
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (2) tick();
        cap.delete();
        d0 = act_done; u0 = act_under;
        send(16'h0000);
        send(16'h0000);
        wait_idle();
        send(16'h7FFF);
        wait_idle();
        check("sd_size", cap.size(), 3 * WORD_W);
        if (cap.size() >= 3 * WORD_W) begin
            check("sd_zero_w0", int'(cap_word(0)), 16'h5555);
            check("sd_zero_w1", int'(cap_word(WORD_W)), 16'h5555);
            check("sd_7fff",    int'(cap_word(2 * WORD_W)), 16'h7FFF);
        end
        check("sd_done",  act_done - d0,  3);
        check("sd_under", act_under - u0, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pdm_serializer
`default_nettype wire
